// File: rtl/window_gen_pkg.sv
// window_gen_pkg: shared FSM states, tap indices and counter sizing for window_3x3_gen.
package window_gen_pkg;
    typedef enum logic [2:0] {S_ACCEPT, S_EMIT, S_WAIT, S_FLUSH, S_DONE} tState;
    localparam int TAP_A   = 0;
    localparam int TAP_B   = 1;
    localparam int TAP_C   = 2;
    localparam int TAP_D   = 3;
    localparam int TAP_FIJ = 4;
    localparam int TAP_E   = 5;
    localparam int TAP_F   = 6;
    localparam int TAP_G   = 7;
    localparam int TAP_H   = 8;
    localparam int NUM_TAPS = 9;
    function automatic int cntWidth(input int w, input int h);
        return $clog2(w * h + w + 1);
    endfunction
endpackage

// File: rtl/window_3x3_gen_line_buffer.sv
// m_line_buffer: circular W x 8 delay line; read-before-write at the shared column pointer.
module m_line_buffer #(
    parameter int pDepth = 512,
    parameter int pAddrW = $clog2(pDepth)
) (
    input  logic              iClk,
    input  logic              iEn,
    input  logic [pAddrW-1:0] ivAddr,
    input  logic [7:0]        iv8Data,
    output logic [7:0]        ov8Data
);
    logic [7:0] rMem [pDepth];

    assign ov8Data = rMem[ivAddr];

    always_ff @(posedge iClk)
        if (iEn) rMem[ivAddr] <= iv8Data;
endmodule

// File: rtl/window_3x3_gen.sv
// window_3x3_gen: streaming zero-padded 3x3 window generator for the denoiser handshake.
// Define WINDOW_GEN_REPLICATE_EN to clamp out-of-image taps to the nearest in-image tap.
module window_3x3_gen
    import window_gen_pkg::*;
#(
    parameter int pImageWidth  = 512,
    parameter int pImageHeight = 512
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic [7:0] iv8Pixel,
    input  logic       iPixelValid,
    output logic       oReady,
    output logic [7:0] ov8Pixel_a,
    output logic [7:0] ov8Pixel_b,
    output logic [7:0] ov8Pixel_c,
    output logic [7:0] ov8Pixel_d,
    output logic [7:0] ov8Pixel_fij,
    output logic [7:0] ov8Pixel_e,
    output logic [7:0] ov8Pixel_f,
    output logic [7:0] ov8Pixel_g,
    output logic [7:0] ov8Pixel_h,
    output logic       oDataValid,
    input  logic       iFilterValid,
    output logic       oFrameDone
);
    localparam int cCntW = cntWidth(pImageWidth, pImageHeight);
    localparam int cColW = $clog2(pImageWidth);
    localparam int cRowW = $clog2(pImageHeight);
    localparam logic [cCntW-1:0] cPixels  = cCntW'(pImageWidth * pImageHeight);
    localparam logic [cCntW-1:0] cPrefill = cCntW'(pImageWidth + 1);
    localparam logic [cColW-1:0] cLastCol = cColW'(pImageWidth - 1);
    localparam logic [cRowW-1:0] cLastRow = cRowW'(pImageHeight - 1);

    tState            rState, wStateNext;
    logic [cCntW-1:0] rFeed;
    logic [cColW-1:0] rPtr;
    logic [cRowW-1:0] rRow;
    logic [cColW-1:0] rCol;
    logic             rLastWin, rLive;
    logic [7:0]       rTap [NUM_TAPS];
    logic [7:0]       rWin [NUM_TAPS];
    logic [7:0]       wTap [NUM_TAPS];
    logic [7:0]       wWin [NUM_TAPS];
    logic [7:0]       wFeedPix, wLb1, wLb2;
    logic             wStep, wEmit, wTop, wBot, wLeft, wRight;

    // rLive holds oReady low for the first cycle out of reset so every output reads 0 in reset
    assign oReady     = (rState == S_ACCEPT) && rLive;
    assign oDataValid = (rState == S_EMIT);
    assign oFrameDone = (rState == S_DONE);
    assign wStep      = (oReady && iPixelValid) || (rState == S_FLUSH);
    assign wEmit      = wStep && (rFeed >= cPrefill);
    assign wFeedPix   = (rState == S_FLUSH) ? 8'd0 : iv8Pixel;

    m_line_buffer #(.pDepth(pImageWidth), .pAddrW(cColW)) uLine1 (
        .iClk(iClk), .iEn(wStep), .ivAddr(rPtr), .iv8Data(wFeedPix), .ov8Data(wLb1)
    );
    m_line_buffer #(.pDepth(pImageWidth), .pAddrW(cColW)) uLine2 (
        .iClk(iClk), .iEn(wStep), .ivAddr(rPtr), .iv8Data(wLb1), .ov8Data(wLb2)
    );

    // Newest column enters on the right: pixels k-2W, k-W, k
    always_comb begin
        wTap[TAP_A]   = rTap[TAP_B];
        wTap[TAP_B]   = rTap[TAP_C];
        wTap[TAP_C]   = wLb2;
        wTap[TAP_D]   = rTap[TAP_FIJ];
        wTap[TAP_FIJ] = rTap[TAP_E];
        wTap[TAP_E]   = wLb1;
        wTap[TAP_F]   = rTap[TAP_G];
        wTap[TAP_G]   = rTap[TAP_H];
        wTap[TAP_H]   = wFeedPix;
    end

    assign wTop   = (rRow == '0);
    assign wBot   = (rRow == cLastRow);
    assign wLeft  = (rCol == '0);
    assign wRight = (rCol == cLastCol);

`ifdef WINDOW_GEN_REPLICATE_EN
    logic [7:0] wRowCl [NUM_TAPS];
    always_comb begin
        wRowCl        = wTap;
        wRowCl[TAP_A] = wTop ? wTap[TAP_D]   : wTap[TAP_A];
        wRowCl[TAP_B] = wTop ? wTap[TAP_FIJ] : wTap[TAP_B];
        wRowCl[TAP_C] = wTop ? wTap[TAP_E]   : wTap[TAP_C];
        wRowCl[TAP_F] = wBot ? wTap[TAP_D]   : wTap[TAP_F];
        wRowCl[TAP_G] = wBot ? wTap[TAP_FIJ] : wTap[TAP_G];
        wRowCl[TAP_H] = wBot ? wTap[TAP_E]   : wTap[TAP_H];
        wWin          = wRowCl;
        wWin[TAP_A]   = wLeft  ? wRowCl[TAP_B]   : wRowCl[TAP_A];
        wWin[TAP_D]   = wLeft  ? wRowCl[TAP_FIJ] : wRowCl[TAP_D];
        wWin[TAP_F]   = wLeft  ? wRowCl[TAP_G]   : wRowCl[TAP_F];
        wWin[TAP_C]   = wRight ? wRowCl[TAP_B]   : wRowCl[TAP_C];
        wWin[TAP_E]   = wRight ? wRowCl[TAP_FIJ] : wRowCl[TAP_E];
        wWin[TAP_H]   = wRight ? wRowCl[TAP_G]   : wRowCl[TAP_H];
    end
`else
    always_comb begin
        wWin          = wTap;
        wWin[TAP_A]   = (wTop || wLeft)  ? 8'd0 : wTap[TAP_A];
        wWin[TAP_B]   = wTop             ? 8'd0 : wTap[TAP_B];
        wWin[TAP_C]   = (wTop || wRight) ? 8'd0 : wTap[TAP_C];
        wWin[TAP_D]   = wLeft            ? 8'd0 : wTap[TAP_D];
        wWin[TAP_E]   = wRight           ? 8'd0 : wTap[TAP_E];
        wWin[TAP_F]   = (wBot || wLeft)  ? 8'd0 : wTap[TAP_F];
        wWin[TAP_G]   = wBot             ? 8'd0 : wTap[TAP_G];
        wWin[TAP_H]   = (wBot || wRight) ? 8'd0 : wTap[TAP_H];
    end
`endif

    always_comb begin
        wStateNext = rState;
        case (rState)
            S_ACCEPT: if (wStep) wStateNext = wEmit ? S_EMIT : ((rFeed == cPixels - 1'b1) ? S_FLUSH : S_ACCEPT);
            S_EMIT:   wStateNext = S_WAIT;
            S_WAIT:   if (iFilterValid) wStateNext = rLastWin ? S_DONE : ((rFeed < cPixels) ? S_ACCEPT : S_FLUSH);
            S_FLUSH:  wStateNext = S_EMIT;
            S_DONE:   wStateNext = S_ACCEPT;
            default:  wStateNext = S_ACCEPT;
        endcase
    end

    // rRow/rCol track the centre of the window produced by the next emitting step
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            rState   <= S_ACCEPT;
            rLive    <= 1'b0;
            rFeed    <= '0;
            rPtr     <= '0;
            rRow     <= '0;
            rCol     <= '0;
            rLastWin <= 1'b0;
            rTap     <= '{default: '0};
            rWin     <= '{default: '0};
        end else begin
            rState <= wStateNext;
            rLive  <= 1'b1;
            if (wStep) begin
                rTap  <= wTap;
                rFeed <= rFeed + 1'b1;
                rPtr  <= (rPtr == cLastCol) ? '0 : rPtr + 1'b1;
            end
            if (wEmit) begin
                rWin     <= wWin;
                rLastWin <= wBot && wRight;
                rCol     <= wRight ? '0 : rCol + 1'b1;
                rRow     <= wRight ? rRow + 1'b1 : rRow;
            end
            if (rState == S_DONE) begin
                rFeed    <= '0;
                rPtr     <= '0;
                rRow     <= '0;
                rCol     <= '0;
                rLastWin <= 1'b0;
            end
        end
    end

    assign ov8Pixel_a   = rWin[TAP_A];
    assign ov8Pixel_b   = rWin[TAP_B];
    assign ov8Pixel_c   = rWin[TAP_C];
    assign ov8Pixel_d   = rWin[TAP_D];
    assign ov8Pixel_fij = rWin[TAP_FIJ];
    assign ov8Pixel_e   = rWin[TAP_E];
    assign ov8Pixel_f   = rWin[TAP_F];
    assign ov8Pixel_g   = rWin[TAP_G];
    assign ov8Pixel_h   = rWin[TAP_H];
endmodule

// File: tb/tb_window_3x3_gen.sv
// tb_window_3x3_gen: randomized self-checking bench for window_3x3_gen (3x3 and 4x3 instances).
// Honours WINDOW_GEN_REPLICATE_EN for the expected edge handling.
module tb_window_3x3_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstN, sel, pv, fvResp, fvSpur, spurEn;
    logic [7:0] pix;
    logic [7:0] t3 [9];
    logic [7:0] t4 [9];
    logic [7:0] tp [9];
    logic rdy3, rdy4, dv3, dv4, fd3, fd4, rdy, dv, fd, prevDv;

    int checks = 0, errors = 0;
    int w, h, respDelay, winCount, fvCount, fdCount, accCount, firstDvAcc;
    logic [7:0] img [16];
    logic [7:0] got [16][9];
    logic [7:0] first [16][9];
    int ref00 [9];
    int ref22 [9];

    window_3x3_gen #(.pImageWidth(3), .pImageHeight(3)) dut3 (
        .iClk(clk), .iRst_n(rstN), .iv8Pixel(pix), .iPixelValid(pv & ~sel), .oReady(rdy3),
        .ov8Pixel_a(t3[0]), .ov8Pixel_b(t3[1]), .ov8Pixel_c(t3[2]), .ov8Pixel_d(t3[3]),
        .ov8Pixel_fij(t3[4]), .ov8Pixel_e(t3[5]), .ov8Pixel_f(t3[6]), .ov8Pixel_g(t3[7]),
        .ov8Pixel_h(t3[8]), .oDataValid(dv3), .iFilterValid((fvResp | fvSpur) & ~sel), .oFrameDone(fd3)
    );
    window_3x3_gen #(.pImageWidth(4), .pImageHeight(3)) dut4 (
        .iClk(clk), .iRst_n(rstN), .iv8Pixel(pix), .iPixelValid(pv & sel), .oReady(rdy4),
        .ov8Pixel_a(t4[0]), .ov8Pixel_b(t4[1]), .ov8Pixel_c(t4[2]), .ov8Pixel_d(t4[3]),
        .ov8Pixel_fij(t4[4]), .ov8Pixel_e(t4[5]), .ov8Pixel_f(t4[6]), .ov8Pixel_g(t4[7]),
        .ov8Pixel_h(t4[8]), .oDataValid(dv4), .iFilterValid((fvResp | fvSpur) & sel), .oFrameDone(fd4)
    );

    assign rdy = sel ? rdy4 : rdy3;
    assign dv  = sel ? dv4 : dv3;
    assign fd  = sel ? fd4 : fd3;
    always_comb for (int i = 0; i < 9; i++) tp[i] = sel ? t4[i] : t3[i];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Reference window: tap t of the window centred on raster pixel n
    function automatic int model(input int n, input int t);
        int r, c, rr, cc;
        r = n / w;
        c = n % w;
        rr = r + t / 3 - 1;
        cc = c + t % 3 - 1;
`ifdef WINDOW_GEN_REPLICATE_EN
        rr = (rr < 0) ? 0 : ((rr >= h) ? h - 1 : rr);
        cc = (cc < 0) ? 0 : ((cc >= w) ? w - 1 : cc);
`else
        if (rr < 0 || rr >= h || cc < 0 || cc >= w) return 0;
`endif
        return int'(img[rr * w + cc]);
    endfunction

    always @(negedge clk) begin
        if (rstN) begin
            if (dv) begin
                int bad;
                bad = -1;
                check("oDataValid single pulse", int'(prevDv), 0);
                if (winCount == 0) firstDvAcc = accCount;
                if (winCount < w * h) begin
                    for (int t = 0; t < 9; t++) begin
                        got[winCount][t] = tp[t];
                        if (bad < 0 && int'(tp[t]) != model(winCount, t)) bad = t;
                    end
                    checks++;
                    if (bad >= 0) begin
                        errors++;
                        $display("FAIL window n=%0d tap %0d: got %0d expected %0d", winCount, bad, tp[bad], model(winCount, bad));
                    end
                end else check("window beyond frame", winCount, w * h - 1);
                winCount++;
            end
            if (fd) begin
                fdCount++;
                check("frame done after last filter response", fvCount, w * h);
            end
        end
        prevDv = dv;
    end

    // Denoiser stand-in: answers respDelay cycles after each oDataValid
    always begin
        @(posedge clk); #1;
        if (rstN && dv) begin
            for (int i = 1; i < respDelay; i++) begin
                @(posedge clk); #1;
                if (rstN) check("oReady low while waiting", int'(rdy), 0);
            end
            fvResp = 1'b1;
            @(posedge clk); #1;
            fvResp = 1'b0;
            if (rstN) fvCount++;
        end
    end

    always begin
        @(posedge clk); #1;
        fvSpur = spurEn && rdy && ($urandom_range(0, 1) == 1);
    end

    task automatic feedFrame(input int mode, input int nPix);
        int idx, cyc;
        bit acc;
        idx = 0;
        cyc = 0;
        while (idx < nPix && cyc < 5000) begin
            pix = img[idx];
            pv = (mode == 0) || (mode == 1 && cyc % 3 == 0) || (mode == 2 && $urandom_range(0, 1) == 1);
            @(negedge clk);
            acc = pv && rdy;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                accCount++;
            end
            cyc++;
        end
        pv = 1'b0;
        if (idx < nPix) check("feed timeout", idx, nPix);
    endtask

    task automatic setup(input int ww, input int hh, input int delay, input bit randImg);
        sel = (ww == 4);
        w = ww;
        h = hh;
        respDelay = delay;
        for (int i = 0; i < 16; i++) img[i] = randImg ? 8'($urandom_range(0, 255)) : 8'(i + 1);
        winCount = 0;
        fvCount = 0;
        fdCount = 0;
        accCount = 0;
        firstDvAcc = -1;
    endtask

    task automatic runFrame(input int ww, input int hh, input int mode, input int delay, input bit spur, input bit randImg);
        int cyc;
        setup(ww, hh, delay, randImg);
        spurEn = spur;
        feedFrame(mode, w * h);
        cyc = 0;
        while (fdCount == 0 && cyc < 2000) begin
            @(posedge clk);
            cyc++;
        end
        spurEn = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("frame done pulses", fdCount, 1);
        check("window count", winCount, w * h);
        check("first window after W+2 pixels", firstDvAcc, w + 2);
    endtask

    task automatic checkIdle(input string name);
        int tapOr;
        tapOr = 0;
        for (int t = 0; t < 9; t++) tapOr = tapOr | int'(tp[t]);
        check({name, " taps"}, tapOr, 0);
        check({name, " oReady"}, int'(rdy), 0);
        check({name, " oDataValid"}, int'(dv), 0);
        check({name, " oFrameDone"}, int'(fd), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rstN = 1'b0; pv = 1'b0; pix = 8'd0; fvResp = 1'b0; fvSpur = 1'b0; spurEn = 1'b0; sel = 1'b0;
        prevDv = 1'b0;
        setup(3, 3, 2, 1'b0);
`ifdef WINDOW_GEN_REPLICATE_EN
        ref00 = '{1, 1, 2, 1, 1, 2, 4, 4, 5};
        ref22 = '{5, 6, 6, 8, 9, 9, 8, 9, 9};
`else
        ref00 = '{0, 0, 0, 0, 1, 2, 0, 4, 5};
        ref22 = '{5, 6, 0, 8, 9, 0, 0, 0, 0};
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkIdle("reset");
        for (int t = 0; t < 9; t++) begin
            check("model centre", model(4, t), t + 1);
            check("model corner 0,0", model(0, t), ref00[t]);
            check("model corner 2,2", model(8, t), ref22[t]);
        end
        #2 rstN = 1'b1;
        @(posedge clk); #1;

        runFrame(3, 3, 0, 2, 1'b0, 1'b0);
        for (int t = 0; t < 9; t++) begin
            check("dut window 0,0", int'(got[0][t]), ref00[t]);
            check("dut window 1,1", int'(got[4][t]), t + 1);
            check("dut window 2,2", int'(got[8][t]), ref22[t]);
        end
        first = got;

        runFrame(3, 3, 0, 20, 1'b0, 1'b0);
        for (int n = 0; n < 9; n++)
            for (int t = 0; t < 9; t++) check("backpressure same as first", int'(got[n][t]), int'(first[n][t]));

        runFrame(4, 3, 0, 2, 1'b0, 1'b0);
        first = got;
        runFrame(4, 3, 1, 2, 1'b0, 1'b0);
        for (int n = 0; n < 12; n++)
            for (int t = 0; t < 9; t++) check("gapped same as back-to-back", int'(got[n][t]), int'(first[n][t]));

        setup(3, 3, 2, 1'b0);
        feedFrame(0, 5);
        @(negedge clk); #2;
        rstN = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkIdle("mid-frame reset");
        #2 rstN = 1'b1;
        @(posedge clk); #1;
        runFrame(3, 3, 0, 2, 1'b0, 1'b0);
        for (int t = 0; t < 9; t++) check("first window after reset", int'(got[0][t]), ref00[t]);

        runFrame(3, 3, 0, 3, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++)
            runFrame((i % 2 == 0) ? 3 : 4, 3, 2, $urandom_range(2, 6), i[1], 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/window_3x3_gen.md
Name: window_3x3_gen

Overview:
- Streaming 3x3 neighbourhood generator that feeds the mTopModule decision-tree denoiser.
- Accepts one raster-order 8-bit pixel stream (row 0 col 0 first).
- Buffers two image lines and emits one zero-padded 3x3 window per centre pixel on the denoiser's iDataValid/oValid handshake.
- Replaces the software windowing done by the top-level bench, so the full pipe is synthesizable.

Parameters:
- pImageWidth, 512, pixels per row (>=3).
- pImageHeight, 512, rows per frame (>=2).

Ports:
- iClk  in  1  clock, all logic on rising edge.
- iRst_n  in  1  asynchronous active-low reset.
- iv8Pixel  in  8  raster input pixel.
- iPixelValid  in  1  iv8Pixel valid; transfer occurs when iPixelValid & oReady.
- oReady  out  1  generator can accept a pixel this cycle.
- ov8Pixel_a/b/c/d/fij/e/f/g/h  out  8 each  window taps (i-1,j-1),(i-1,j),(i-1,j+1),(i,j-1),(i,j),(i,j+1),(i+1,j-1),(i+1,j),(i+1,j+1); to denoiser iv8Pixel_*.
- oDataValid  out  1  one-cycle pulse: window taps valid; drives denoiser iDataValid.
- iFilterValid  in  1  denoiser oValid; completes the current window transaction.
- oFrameDone  out  1  one-cycle pulse after the last window of a frame completes.

Behaviour:
- Reset: all outputs 0, FSM = S_ACCEPT, counters 0, line buffers not cleared (padding masks stale data).
- Feed index k counts 0..W*H+W: one step per real or virtual pixel. Indices < W*H are real (taken from input); indices >= W*H are virtual zeros generated internally.
- Storage: two line buffers (W x 8, circular, shared column pointer) plus a 3x3 tap register shifted on every feed step.
- Emission rule: feed step k >= W+1 emits the window centred on pixel n = k-W-1, with row r = n/W and col c = n%W. Steps k <= W emit nothing (prefill).
- Zero padding, applied by masking taps at emission:
  - r==0 zeroes a,b,c.
  - r==H-1 zeroes f,g,h.
  - c==0 zeroes a,d,f.
  - c==W-1 zeroes c,e,h.
- FSM states:
  - S_ACCEPT: oReady=1. A transfer performs a feed step. If that step emits, go to S_EMIT; else stay. After the transfer with k==W*H-1, go to S_FLUSH if nothing emits, else S_EMIT.
  - S_EMIT: oDataValid=1 for exactly one cycle; taps hold until the next feed step. Go to S_WAIT.
  - S_WAIT: oReady=0. On iFilterValid: if n==W*H-1, go to S_DONE; else if k<W*H, go to S_ACCEPT; else go to S_FLUSH.
  - S_FLUSH: oReady=0. One virtual feed step per cycle, then S_EMIT.
  - S_DONE: oFrameDone=1 for one cycle, counters cleared, go to S_ACCEPT.
- Latency: window output and oDataValid appear the cycle after the accepting edge (1 cycle).
- iFilterValid outside S_WAIT is ignored. iPixelValid while oReady=0 is not consumed; upstream holds the pixel.
- iRst_n asserted mid-frame aborts at once: all outputs to 0, next pixel is treated as (0,0).
- Column pointer wraps W-1 -> 0. k and n widths are $clog2(W*H+W+1).

Optional Feature:
- WINDOW_GEN_REPLICATE_EN defined: out-of-image taps take the nearest in-image tap (clamp) instead of 0.
  - Top edge: a,b,c take d,fij,e.
  - Bottom edge: f,g,h take d,fij,e.
  - Left edge: a,d,f take b,fij,g.
  - Right edge: c,e,h take b,fij,g.
  - Corners: apply the row clamp, then the column clamp.
- Undefined: zero padding as in Behaviour.

Decomposition:
- Package window_gen_pkg: FSM state enum (S_ACCEPT, S_EMIT, S_WAIT, S_FLUSH, S_DONE), tap index constants 0..8 (a..h order above), function for counter width.
- Sub-module m_line_buffer: single-port circular W x 8 delay line with enable, instantiated twice.

Test Plan:
- 3x3 image 1..9, zero pad, denoiser model answers iFilterValid 2 cycles after oDataValid -> 9 windows.
  - Centre (1,1): 1,2,3,4,5,6,7,8,9.
  - (0,0): a..d=0, fij=1, e=2, f=0, g=4, h=5.
  - oFrameDone pulses once, after the 9th iFilterValid.
- Same image with WINDOW_GEN_REPLICATE_EN -> (0,0) window a=1,b=1,c=2,d=1,fij=1,e=2,f=4,g=4,h=5; (2,2): c,e,h=6,9,9 and f,g,h=8,9,9, resolved per the corner rule.
- Backpressure: iFilterValid delayed 20 cycles -> oReady stays 0 throughout S_WAIT, no pixel lost, output sequence identical to the first test.
- iPixelValid gaps (valid every 3rd cycle) on a 4x3 image -> windows identical to back-to-back feed; first oDataValid follows the 6th accepted pixel (W+2).
- Reset mid-frame after 5 pixels, then a fresh 3x3 frame -> outputs 0 during reset, first window equals the (0,0) window of the new frame.
- Spurious iFilterValid during S_ACCEPT -> ignored, window count still W*H.
